// File: rtl/mux2_feeder_pkg.sv
// Shared types for the 2:1 round-robin mux feeder (mux2_rr_feeder, chan_fifo).
// Optional feature macro: MUX2_FEEDER_STALL_CNT_EN (adds the stall_cnt port on the top).
package mux2_feeder_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned PTR_W     = $clog2(DEPTH_DEF);
    localparam int unsigned STALL_W   = 16;

    typedef enum logic {CH0 = 1'b0, CH1 = 1'b1} chan_t;

    // Round-robin pick: alternate on a tie, otherwise take the only non-empty channel.
    function automatic chan_t rr_pick(input logic ne0, input logic ne1, input chan_t last);
        if (ne0 && ne1) begin
            return (last == CH0) ? CH1 : CH0;
        end else if (ne0) begin
            return CH0;
        end
        return CH1;
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel FIFO with count-based full/empty; head is always visible on rdata.
module chan_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/mux2_rr_feeder.sv
// Two buffered valid/ready inputs, round-robin arbitrated into registered d0/d1/s.
// Optional: MUX2_FEEDER_STALL_CNT_EN adds a saturating stall_cnt output.
module mux2_rr_feeder
    import mux2_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic             s,
    output logic             y_valid,
    input  logic             y_ready
`ifdef MUX2_FEEDER_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    logic             full0, full1, empty0, empty1;
    logic             push0, push1, pop0, pop1;
    logic [WIDTH-1:0] head0, head1;
    logic             load;
    chan_t            grant;

    logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    chan_t            s_q, s_d, last_q, last_d;
    logic             y_valid_q, y_valid_d;

    assign in0_ready = !full0;
    assign in1_ready = !full1;
    assign push0     = in0_valid && !full0;
    assign push1     = in1_valid && !full1;

    chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .reset(reset), .push(push0), .pop(pop0),
        .wdata(in0_data), .rdata(head0), .full(full0), .empty(empty0)
    );

    chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset), .push(push1), .pop(pop1),
        .wdata(in1_data), .rdata(head1), .full(full1), .empty(empty1)
    );

    // Arbitration and output-stage next state; only the granted dN is rewritten.
    always_comb begin
        d0_d      = d0_q;
        d1_d      = d1_q;
        s_d       = s_q;
        last_d    = last_q;
        y_valid_d = y_valid_q;
        load      = (!y_valid_q || y_ready) && (!empty0 || !empty1);
        grant     = rr_pick(!empty0, !empty1, last_q);
        pop0      = load && (grant == CH0);
        pop1      = load && (grant == CH1);
        if (load) begin
            if (grant == CH0) d0_d = head0;
            else              d1_d = head1;
            s_d       = grant;
            last_d    = grant;
            y_valid_d = 1'b1;
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0_q      <= '0;
            d1_q      <= '0;
            s_q       <= CH0;
            last_q    <= CH1;
            y_valid_q <= 1'b0;
        end else begin
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            s_q       <= s_d;
            last_q    <= last_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign d0      = d0_q;
    assign d1      = d1_q;
    assign s       = s_q;
    assign y_valid = y_valid_q;

`ifdef MUX2_FEEDER_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (y_valid_q && !y_ready && (stall_q != {STALL_W{1'b1}}))
            stall_d = stall_q + STALL_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mux2_rr_feeder.sv
// Self-checking bench for mux2_rr_feeder against a queue-based reference model.
// Build with MUX2_FEEDER_STALL_CNT_EN to also cover stall_cnt.
module tb_mux2_rr_feeder;

    localparam int unsigned W = 4;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in0_valid, in1_valid, y_ready;
    logic [W-1:0] in0_data, in1_data;
    logic         in0_ready, in1_ready;
    logic [W-1:0] d0, d1;
    logic         s, y_valid;
`ifdef MUX2_FEEDER_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int   q0[$];
    int   q1[$];
    int   m_d0, m_d1, m_s, m_yv, m_last;
    int   m_cnt;

    mux2_rr_feeder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
        .d0(d0), .d1(d1), .s(s), .y_valid(y_valid), .y_ready(y_ready)
`ifdef MUX2_FEEDER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_d0 = 0; m_d1 = 0; m_s = 0; m_yv = 0; m_last = 1; m_cnt = 0;
    endtask

    task automatic compare_all();
        chk("y_valid", 32'(y_valid), 32'(m_yv));
        chk("s", 32'(s), 32'(m_s));
        chk("d0", 32'(d0), 32'(m_d0));
        chk("d1", 32'(d1), 32'(m_d1));
        chk("in0_ready", 32'(in0_ready), 32'(q0.size() < D));
        chk("in1_ready", 32'(in1_ready), 32'(q1.size() < D));
`ifdef MUX2_FEEDER_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic drive(input logic v0, input int dat0, input logic v1, input int dat1,
                         input logic yr);
        in0_valid = v0; in0_data = W'(dat0);
        in1_valid = v1; in1_data = W'(dat1);
        y_ready   = yr;
    endtask

    // One clock: model decides from pre-edge state and inputs, then compares after the edge.
    task automatic tick();
        bit ne0, ne1, p0, p1, ld, g, yr;
        int a0, a1;
        ne0 = q0.size() != 0;
        ne1 = q1.size() != 0;
        p0  = in0_valid && (q0.size() < D);
        p1  = in1_valid && (q1.size() < D);
        a0  = int'(in0_data);
        a1  = int'(in1_data);
        yr  = y_ready;
        ld  = (m_yv == 0 || yr) && (ne0 || ne1);
        g   = (ne0 && ne1) ? (m_last == 0) : !ne0;
        if (m_yv != 0 && !yr && m_cnt < 65535) m_cnt++;
        @(posedge clk);
        #1;
        if (ld) begin
            if (!g) m_d0 = q0.pop_front();
            else    m_d1 = q1.pop_front();
            m_s = int'(g); m_last = int'(g); m_yv = 1;
        end else if (yr) begin
            m_yv = 0;
        end
        if (p0) q0.push_back(a0);
        if (p1) q1.push_back(a1);
        compare_all();
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        int got[$];
        int idx;
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        #2;
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Alternation: ties go CH0 first, then alternate.
        hard_reset();
        drive(1, 'h3, 1, 'hA, 1); tick();
        drive(1, 'h5, 1, 'hC, 1); tick();
        chk("alt0_s", 32'(s), 0); chk("alt0_v", 32'(d0), 'h3);
        drive(0, 0, 0, 0, 1); tick();
        chk("alt1_s", 32'(s), 1); chk("alt1_v", 32'(d1), 'hA);
        tick();
        chk("alt2_s", 32'(s), 0); chk("alt2_v", 32'(d0), 'h5);
        tick();
        chk("alt3_s", 32'(s), 1); chk("alt3_v", 32'(d1), 'hC);
        tick();
        chk("alt_idle", 32'(y_valid), 0);

        // Single channel on ch1
        hard_reset();
        drive(0, 0, 1, 1, 1); tick();
        drive(0, 0, 1, 2, 1); tick();
        chk("sc1", 32'({s, d1, d0}), 32'({1'b1, 4'h1, 4'h0}));
        drive(0, 0, 1, 3, 1); tick();
        chk("sc2", 32'({s, d1, d0}), 32'({1'b1, 4'h2, 4'h0}));
        drive(0, 0, 0, 0, 1); tick();
        chk("sc3", 32'({s, d1, d0}), 32'({1'b1, 4'h3, 4'h0}));

        // Backpressure: 4 in FIFO plus 1 in the output stage
        hard_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1, i, 0, 0, 0); tick();
        end
        chk("bp_ready", 32'(in0_ready), 0);
        drive(1, 6, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", 32'({y_valid, s, d0}), 32'({1'b1, 1'b0, 4'h1}));
        end
        drive(0, 0, 0, 0, 1);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("bp_drain", 32'(d0), 32'(i));
        end
        tick();
        chk("bp_empty", 32'(y_valid), 0);

        // Wrap: 10 beats through ch0 with y_ready toggling
        hard_reset();
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            drive(idx < 10, idx, 0, 0, c[0]);
            if (y_valid && y_ready) got.push_back(int'(d0));
            if (idx < 10 && q0.size() < D) begin
                tick(); idx++;
            end else begin
                tick();
            end
        end
        chk("wrap_cnt", 32'(got.size()), 10);
        for (int i = 0; i < got.size() && i < 10; i++) chk("wrap_order", 32'(got[i]), 32'(i));

        // Reset mid-stream with both FIFOs holding 2 entries
        hard_reset();
        drive(1, 1, 1, 8, 0); tick();
        drive(1, 2, 1, 9, 0); tick();
        drive(1, 3, 0, 0, 0); tick();
        chk("rst_pre_q", 32'({q0.size(), q1.size()}) , 32'({32'd2, 32'd2}));
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async", 32'({y_valid, s, d0, d1, in0_ready, in1_ready}),
            32'({1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1}));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all();
        drive(1, 4, 1, 7, 1); tick();
        drive(0, 0, 0, 0, 1); tick();
        chk("rst_first_grant", 32'({s, d0}), 32'({1'b0, 4'h4}));
        tick();
        chk("rst_second_grant", 32'({s, d1}), 32'({1'b1, 4'h7}));

        // Randomized traffic
        hard_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 9) < 7);
            tick();
        end

`ifdef MUX2_FEEDER_STALL_CNT_EN
        hard_reset();
        drive(1, 5, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 7; i++) tick();
        chk("stall7", 32'(stall_cnt), 7);
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        chk("stall_sat", 32'(stall_cnt), 'hFFFF);
        m_cnt = 65535;
        tick();
        chk("stall_sat_hold", 32'(stall_cnt), 'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
